seven_segment_scan: RTL and testbench
=====================================

Name: seven_segment_scan

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display.
- Successor to the single-digit combinational hex decoder: adds the refresh timebase, digit scanning, per-digit blanking, decimal points, leading-zero suppression and frame-coherent input capture.
- Sits between score/counter logic (e.g. Pong scores) and the board segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 100000, clock cycles each digit stays lit (>=2).
- LZ_BLANK, 0, 1 = suppress leading zeros (digit 0 never suppressed).

Ports:
- Clk, input, 1, system clock.
- Rst, input, 1, asynchronous, active-low reset.
- En, input, 1, 1 = display active; 0 = all digits dark.
- DigitsIn, input, 4*NUM_DIGITS, hex nibbles; digit k = bits [4k+3:4k]; digit 0 is rightmost.
- DpIn, input, NUM_DIGITS, decimal point per digit (1 = lit).
- BlankIn, input, NUM_DIGITS, 1 = force digit k dark.
- SegOut, output, 7, active-low segments; [6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g.
- DpOut, output, 1, active-low decimal point.
- AnOut, output, NUM_DIGITS, active-low anode enables; one-hot-low when lit.
- FrameTick, output, 1, one-cycle pulse when a new snapshot is taken.

Behaviour:
Reset (Rst=0, asynchronous):
- SegOut=7'h7F, DpOut=1, AnOut=all 1s, FrameTick=0.
- Divider=0, digit index=0, snapshot registers=0.

Timebase:
- Divider counts 0..REFRESH_DIV-1 and wraps.
- Terminal count (TC) occurs when divider = REFRESH_DIV-1.

Digit index:
- Advances on TC: 0,1,...,NUM_DIGITS-1, then wraps to 0.

Snapshot:
- On TC with index = NUM_DIGITS-1, latch DigitsIn, DpIn and BlankIn into snapshot registers.
- FrameTick=1 in the following cycle only.
- Inputs are sampled only at this point, so a value never tears mid-frame.

Leading-zero mask (LZ_BLANK=1):
- Computed from the snapshot.
- Digit k>0 is suppressed iff it and every higher digit are 0.
- LZ_BLANK=0: mask is all 0.

Output stage (registered):
- Each cycle, for the current index i:
  - AnOut = ~(1<<i) if En=1 and ~BlankIn_snap[i] and ~lz[i]; otherwise all 1s.
  - SegOut = decode(snap digit i) when lit, else 7'h7F.
  - DpOut = ~DpIn_snap[i] when lit, else 1.
- Latency: outputs reflect a new index one cycle after TC.
- SegOut and AnOut change in the same cycle, so there is no ghosting from a stale segment pattern.

Decode (active-low, a..g):
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
- 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.

Boundary conditions:
- En=0: divider and index keep running; only outputs are dark.
- NUM_DIGITS=1: index is constant 0 and every TC snapshots.
- Reset released mid-scan: restarts at index 0 with the snapshot all zero.
  - First snapshot occurs after NUM_DIGITS*REFRESH_DIV cycles.
  - Until then, digit 0 displays '0'; with LZ_BLANK=1, higher digits are dark.
- Input changes on the snapshot cycle are captured; changes one cycle later wait a full frame.

Decomposition:
- Shared package seg_pkg:
  - SEG_BLANK=7'h7F.
  - Bit-position constants SEG_A..SEG_G.
  - function hex_to_seg(4-bit) returning active-low a..g.
- Sub-module seg_decode: combinational nibble-to-segment decode. Replaces the old single-digit decoder for new designs.
- Divider, index, snapshot, LZ mask and output registers stay in seven_segment_scan.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
- Reset: Rst=0 mid-frame -> same cycle SegOut=7F, AnOut=4'hF, DpOut=1. Release -> FrameTick first pulses 16 cycles after release.
- Scan/decode: DigitsIn=16'h1A3F, En=1, after one frame -> AnOut sequence E,D,B,7, each held 4 cycles, with SegOut 0111000(F), 0000110(3), 0001000(A), 1001111(1).
- Tearing: change DigitsIn 16'h1234->16'h5678 while index=1 -> remainder of frame shows 1234; next frame shows 5678, starting the cycle after FrameTick.
- Blank/DP: BlankIn=4'b0100, DpIn=4'b0001 -> digit 2 slot AnOut=F, SegOut=7F; digit 0 slot DpOut=0; all other slots DpOut=1.
- Leading zeros (LZ_BLANK=1): 16'h0040 -> digits 3 and 2 dark, digit 1 '4', digit 0 '0'. 16'h0000 -> only digit 0 lit with '0'.
- Enable: En=0 for 10 cycles mid-frame -> AnOut=F from the next cycle; En=1 resumes at the correct free-running index with no index reset.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment constants and hex decode function
//
// Purpose: segment bit positions, the all-dark pattern and the active-low
// hex-to-segment table used by every seven-segment block.
// Contents:
//   SEG_BLANK        7'h7F, every segment off (active-low)
//   SEG_A .. SEG_G   bit positions of each segment in a 7-bit a..g vector
//   hex_to_seg()     4-bit nibble -> active-low {a,b,c,d,e,f,g}
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational nibble to active-low segment decoder
//
// Purpose: single-digit hex decoder, the drop-in for the old standalone
// decoder in new designs.
// Ports:
//   nibble  in  4  hex value to display
//   seg     out 7  active-low segments, [6]=a .. [0]=g
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - time-multiplexed N-digit seven-segment driver
//
// Purpose: scans NUM_DIGITS common-anode digits, REFRESH_DIV cycles each,
// from a frame-coherent snapshot of the inputs, with per-digit blanking,
// decimal points and optional leading-zero suppression.
// Ports:
//   Clk        in  1              system clock
//   Rst        in  1              asynchronous active-low reset
//   En         in  1              1 = display active, 0 = all digits dark
//   DigitsIn   in  4*NUM_DIGITS   hex nibbles, digit k at [4k+3:4k], 0 rightmost
//   DpIn       in  NUM_DIGITS     decimal point per digit (1 = lit)
//   BlankIn    in  NUM_DIGITS     1 = force digit dark
//   SegOut     out 7              active-low segments a..g
//   DpOut      out 1              active-low decimal point
//   AnOut      out NUM_DIGITS     active-low anode enables
//   FrameTick  out 1              one-cycle pulse after a new snapshot
module seven_segment_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    En,
  input  logic [4*NUM_DIGITS-1:0] DigitsIn,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  input  logic [NUM_DIGITS-1:0]   BlankIn,
  output logic [6:0]              SegOut,
  output logic                    DpOut,
  output logic [NUM_DIGITS-1:0]   AnOut,
  output logic                    FrameTick
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [DW-1:0]           div_q;
  logic [IW-1:0]           idx_q;
  logic [IW-1:0]           idx_next;
  logic                    tc;
  logic                    snap_take;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    lz_run;
  logic [3:0]              cur_nibble;
  logic [6:0]              cur_seg;
  logic                    lit;

  always_comb begin
    tc        = (div_q == DIV_LAST);
    snap_take = tc && (idx_q == IDX_LAST);
    idx_next  = idx_q;
    if (tc) begin
      idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  // Digit 0 is never suppressed so a zero value still shows '0'.
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    if (LZ_BLANK != 0) begin
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        lz_run     = lz_run & (snap_digits[4*k +: 4] == 4'h0);
        lz_mask[k] = lz_run;
      end
    end
  end

  // The output registers are loaded from idx_next so the anode and segment
  // pattern both switch to the new digit on the cycle right after TC.
  always_comb begin
    cur_nibble = snap_digits[idx_next*4 +: 4];
    lit        = En & ~snap_blank[idx_next] & ~lz_mask[idx_next];
  end

  seg_decode u_decode (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      div_q       <= '0;
      idx_q       <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      FrameTick   <= 1'b0;
      SegOut      <= SEG_BLANK;
      DpOut       <= 1'b1;
      AnOut       <= '1;
    end else begin
      div_q     <= tc ? '0 : div_q + DW'(1);
      idx_q     <= idx_next;
      FrameTick <= snap_take;
      if (snap_take) begin
        snap_digits <= DigitsIn;
        snap_dp     <= DpIn;
        snap_blank  <= BlankIn;
      end
      if (lit) begin
        AnOut  <= ~(NUM_DIGITS'(1) << idx_next);
        SegOut <= cur_seg;
        DpOut  <= ~snap_dp[idx_next];
      end else begin
        AnOut  <= '1;
        SegOut <= SEG_BLANK;
        DpOut  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// tb/tb_seven_segment_scan.sv - directed self-checking bench for seven_segment_scan
module tb_seven_segment_scan;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0111000;
  localparam logic [6:0] SX = 7'h7F;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        En = 1'b0;
  logic [15:0] DigitsIn = 16'h0;
  logic [3:0]  DpIn = 4'h0;
  logic [3:0]  BlankIn = 4'h0;

  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [3:0]  an0, an1;
  logic        ft0, ft1;

  int checks = 0;
  int errors = 0;
  int first_tick;

  always #5 Clk = ~Clk;

  seven_segment_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(0)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .DigitsIn(DigitsIn), .DpIn(DpIn),
    .BlankIn(BlankIn), .SegOut(seg0), .DpOut(dp0), .AnOut(an0), .FrameTick(ft0)
  );

  seven_segment_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(1)) dut_lz (
    .Clk(Clk), .Rst(Rst), .En(En), .DigitsIn(DigitsIn), .DpIn(DpIn),
    .BlankIn(BlankIn), .SegOut(seg1), .DpOut(dp1), .AnOut(an1), .FrameTick(ft1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the bench just after the snapshot edge (FrameTick high).
  task automatic wait_frame(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (ft0 === 1'b1) seen = 1;
    end
    chk({tag, " frametick_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, " frametick_lz"}, {31'd0, ft1}, 32'd1);
  endtask

  // Checks cycles first..last after the snapshot edge; slot d covers
  // cycles 4d..4d+3. Expectations are packed digit 3 .. digit 0.
  task automatic check_frame(input string tag, input int first, input int last,
                             input logic [15:0] an_e0, input logic [27:0] seg_e0,
                             input logic [15:0] an_e1, input logic [27:0] seg_e1,
                             input logic [3:0] dp_e);
    int d;
    for (int c = first; c <= last; c++) begin
      tick();
      d = c / 4;
      chk($sformatf("%s an c%0d", tag, c), {28'd0, an0}, {28'd0, an_e0[4*d +: 4]});
      chk($sformatf("%s seg c%0d", tag, c), {25'd0, seg0}, {25'd0, seg_e0[7*d +: 7]});
      chk($sformatf("%s dp c%0d", tag, c), {31'd0, dp0}, {31'd0, dp_e[d]});
      chk($sformatf("%s an_lz c%0d", tag, c), {28'd0, an1}, {28'd0, an_e1[4*d +: 4]});
      chk($sformatf("%s seg_lz c%0d", tag, c), {25'd0, seg1}, {25'd0, seg_e1[7*d +: 7]});
    end
  endtask

  initial begin
    // Held in reset from time 0.
    repeat (3) tick();
    chk("rst seg", {25'd0, seg0}, {25'd0, SX});
    chk("rst an", {28'd0, an0}, 32'hF);
    chk("rst dp", {31'd0, dp0}, 32'd1);
    chk("rst ft", {31'd0, ft0}, 32'd0);

    // First release: snapshot is zero, digit 0 shows '0', LZ instance
    // keeps the higher digits dark.
    En = 1'b1;
    @(negedge Clk) Rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("post_rst an k%0d", k), {28'd0, an0}, (k < 4) ? 32'hE : 32'hD);
      chk($sformatf("post_rst seg k%0d", k), {25'd0, seg0}, {25'd0, S0});
      chk($sformatf("post_rst an_lz k%0d", k), {28'd0, an1}, (k < 4) ? 32'hE : 32'hF);
      chk($sformatf("post_rst seg_lz k%0d", k), {25'd0, seg1}, (k < 4) ? {25'd0, S0} : {25'd0, SX});
    end

    // Asynchronous reset mid-frame: outputs dark without a clock edge.
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("async_rst seg", {25'd0, seg0}, {25'd0, SX});
    chk("async_rst an", {28'd0, an0}, 32'hF);
    chk("async_rst dp", {31'd0, dp0}, 32'd1);
    chk("async_rst an_lz", {28'd0, an1}, 32'hF);
    repeat (2) tick();
    @(negedge Clk) Rst = 1'b1;
    first_tick = 0;
    for (int k = 1; k <= 40 && first_tick == 0; k++) begin
      tick();
      if (ft0 === 1'b1) first_tick = k;
    end
    chk("frametick_latency", first_tick, 32'd16);

    // Scan and decode of 1A3F.
    DigitsIn = 16'h1A3F;
    wait_frame("scan");
    check_frame("scan", 1, 15, 16'h7BDE, {S1, SA, S3, SF}, 16'h7BDE, {S1, SA, S3, SF}, 4'hF);

    // Tearing: 5678 applied while digit 1 is shown waits for the next frame.
    DigitsIn = 16'h1234;
    wait_frame("tear_a");
    check_frame("tear_a", 1, 5, 16'h7BDE, {S1, S2, S3, S4}, 16'h7BDE, {S1, S2, S3, S4}, 4'hF);
    DigitsIn = 16'h5678;
    check_frame("tear_b", 6, 15, 16'h7BDE, {S1, S2, S3, S4}, 16'h7BDE, {S1, S2, S3, S4}, 4'hF);
    tick();
    chk("tear ft", {31'd0, ft0}, 32'd1);
    chk("tear stale_seg", {25'd0, seg0}, {25'd0, S4});
    check_frame("tear_c", 1, 15, 16'h7BDE, {S5, S6, S7, S8}, 16'h7BDE, {S5, S6, S7, S8}, 4'hF);

    // Blanking and decimal point.
    BlankIn = 4'b0100;
    DpIn    = 4'b0001;
    wait_frame("blank");
    check_frame("blank", 1, 15, 16'h7FDE, {S5, SX, S7, S8}, 16'h7FDE, {S5, SX, S7, S8}, 4'b1110);

    // Leading zeros.
    BlankIn  = 4'b0000;
    DpIn     = 4'b0000;
    DigitsIn = 16'h0040;
    wait_frame("lz40");
    check_frame("lz40", 1, 15, 16'h7BDE, {S0, S0, S4, S0}, 16'hFFDE, {SX, SX, S4, S0}, 4'hF);
    DigitsIn = 16'h0000;
    wait_frame("lz00");
    check_frame("lz00", 1, 15, 16'h7BDE, {S0, S0, S0, S0}, 16'hFFFE, {SX, SX, SX, S0}, 4'hF);

    // Enable low for 10 cycles mid-frame; scanning continues underneath.
    DigitsIn = 16'h1A3F;
    wait_frame("en");
    check_frame("en_on", 1, 5, 16'h7BDE, {S1, SA, S3, SF}, 16'h7BDE, {S1, SA, S3, SF}, 4'hF);
    En = 1'b0;
    check_frame("en_off", 6, 15, 16'hFFFF, {SX, SX, SX, SX}, 16'hFFFF, {SX, SX, SX, SX}, 4'hF);
    En = 1'b1;
    tick();
    chk("en ft", {31'd0, ft0}, 32'd1);
    chk("en resume_an", {28'd0, an0}, 32'hE);
    check_frame("en_back", 1, 15, 16'h7BDE, {S1, SA, S3, SF}, 16'h7BDE, {S1, SA, S3, SF}, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
